// File: rtl/projeto_pkg.sv
// Shared definitions for the polynomial evaluator front end.
//   W_PADRAO    : default operand width of the evaluator datapath
//   PROF_PADRAO : default operand-set FIFO depth
//   estado_t    : operand feeder FSM states
//   operandos_t : one operand set {x, a, b, c} at the default width
package projeto_pkg;

    localparam int unsigned W_PADRAO    = 16;
    localparam int unsigned PROF_PADRAO = 4;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        DISPARA = 2'd1,
        ESPERA  = 2'd2
    } estado_t;

    typedef struct packed {
        logic [W_PADRAO-1:0] x;
        logic [W_PADRAO-1:0] a;
        logic [W_PADRAO-1:0] b;
        logic [W_PADRAO-1:0] c;
    } operandos_t;

endpackage

// File: rtl/fifo_sincrona.sv
// Single-clock FIFO with wrap-bit pointers and a registered occupancy count.
// A push while full is refused even if a pop happens in the same cycle.
//   ck, rst     : clock, synchronous active-high reset
//   push, din   : write request and data (ignored when cheio)
//   pop, dout   : read request (ignored when vazio) and head of queue
//   cheio, vazio: full / empty, decoded from the pointers
//   nivel       : entries currently stored
module fifo_sincrona #(
    parameter int unsigned LARGURA = 64,
    parameter int unsigned PROF    = 4
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     push,
    input  logic [LARGURA-1:0]       din,
    input  logic                     pop,
    output logic [LARGURA-1:0]       dout,
    output logic                     cheio,
    output logic                     vazio,
    output logic [$clog2(PROF):0]    nivel
);

    localparam int unsigned AW = $clog2(PROF);
    localparam int unsigned PW = AW + 1;

    logic [LARGURA-1:0] mem [PROF];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic               escreve;
    logic               le;

    // Same index with different wrap bits means the writer lapped the reader.
    assign vazio   = (wr_ptr == rd_ptr);
    assign cheio   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign escreve = push && !cheio;
    assign le      = pop && !vazio;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointers and occupancy.
    always_ff @(posedge ck) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            nivel  <= '0;
        end else begin
            if (escreve) wr_ptr <= wr_ptr + PW'(1);
            if (le)      rd_ptr <= rd_ptr + PW'(1);
            case ({escreve, le})
                2'b10:   nivel <= nivel + PW'(1);
                2'b01:   nivel <= nivel - PW'(1);
                default: nivel <= nivel;
            endcase
        end
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge ck) begin
        if (escreve) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/carregador_operandos.sv
// Operand feeder for the polynomial evaluator: buffers operand sets and
// launches one evaluation at a time, holding operands until completion.
//   ck, rst                     : clock, synchronous active-high reset
//   ent_valido, ent_pronto      : producer handshake (push on both high)
//   ent_X, ent_A, ent_B, ent_C  : incoming operand set
//   inicio                      : one-cycle start pulse to the evaluator
//   X, A, B, C                  : registered operands, stable during a job
//   fim                         : evaluator completion pulse
//   ocupado                     : a job has been launched and not finished
//   nivel                       : operand sets waiting in the FIFO
module carregador_operandos
    import projeto_pkg::*;
#(
    parameter int unsigned W    = W_PADRAO,
    parameter int unsigned PROF = PROF_PADRAO
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic                     ent_valido,
    output logic                     ent_pronto,
    input  logic [W-1:0]             ent_X,
    input  logic [W-1:0]             ent_A,
    input  logic [W-1:0]             ent_B,
    input  logic [W-1:0]             ent_C,
    output logic                     inicio,
    output logic [W-1:0]             X,
    output logic [W-1:0]             A,
    output logic [W-1:0]             B,
    output logic [W-1:0]             C,
    input  logic                     fim,
    output logic                     ocupado,
    output logic [$clog2(PROF):0]    nivel
);

    localparam int unsigned LARGURA = 4 * W;

    estado_t            estado;
    estado_t            estado_prox;
    logic               carrega;
    logic               cheio;
    logic               vazio;
    logic [LARGURA-1:0] cabeca;

    fifo_sincrona #(
        .LARGURA (LARGURA),
        .PROF    (PROF)
    ) u_fifo (
        .ck    (ck),
        .rst   (rst),
        .push  (ent_valido),
        .din   ({ent_X, ent_A, ent_B, ent_C}),
        .pop   (carrega),
        .dout  (cabeca),
        .cheio (cheio),
        .vazio (vazio),
        .nivel (nivel)
    );

    // No bypass: readiness depends only on stored occupancy.
    assign ent_pronto = !cheio;

    // Next-state logic; the head is popped on the same edge it is loaded.
    always_comb begin
        estado_prox = estado;
        carrega     = 1'b0;
        case (estado)
            OCIOSO: begin
                if (!vazio) begin
                    carrega     = 1'b1;
                    estado_prox = DISPARA;
                end
            end
            DISPARA: estado_prox = ESPERA;
            ESPERA:  if (fim) estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
    end

    // State, start pulse, busy flag and operand registers.
    always_ff @(posedge ck) begin
        if (rst) begin
            estado  <= OCIOSO;
            inicio  <= 1'b0;
            ocupado <= 1'b0;
            X       <= '0;
            A       <= '0;
            B       <= '0;
            C       <= '0;
        end else begin
            estado  <= estado_prox;
            inicio  <= (estado_prox == DISPARA);
            ocupado <= (estado_prox != OCIOSO);
            if (carrega) {X, A, B, C} <= cabeca;
        end
    end

endmodule

// File: tb/tb_carregador_operandos.sv
module tb_carregador_operandos;
    import projeto_pkg::*;

    localparam int unsigned W    = 16;
    localparam int unsigned PROF = 4;
    localparam int unsigned NW   = $clog2(PROF) + 1;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic          rst;
    logic          ent_valido;
    logic          ent_pronto;
    logic [W-1:0]  ent_X, ent_A, ent_B, ent_C;
    logic          inicio;
    logic [W-1:0]  X, A, B, C;
    logic          fim;
    logic          ocupado;
    logic [NW-1:0] nivel;

    carregador_operandos #(.W(W), .PROF(PROF)) dut (
        .ck         (ck),
        .rst        (rst),
        .ent_valido (ent_valido),
        .ent_pronto (ent_pronto),
        .ent_X      (ent_X),
        .ent_A      (ent_A),
        .ent_B      (ent_B),
        .ent_C      (ent_C),
        .inicio     (inicio),
        .X          (X),
        .A          (A),
        .B          (B),
        .C          (C),
        .fim        (fim),
        .ocupado    (ocupado),
        .nivel      (nivel)
    );

    int n_ok  = 0;
    int n_tot = 0;

    bit ativo_mon  = 1'b0;
    bit auto_fim   = 1'b0;
    int fim_atraso = 0;
    int pedidos    = 0;
    int atendidos  = 0;
    int cont       = 0;

    // Reference model: jobs accepted but not yet launched, in arrival order.
    operandos_t modelo[$];
    operandos_t ultimo     = '0;
    bit         em_uso     = 1'b0;
    bit         inicio_ant = 1'b0;

    task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nome, got, exp, $time);
    endtask

    function automatic operandos_t aleatorio();
        operandos_t r;
        r.x = 16'($urandom);
        r.a = 16'($urandom);
        r.b = 16'($urandom);
        r.c = 16'($urandom);
        return r;
    endfunction

    // Model update at the edge, checks half a cycle later.
    initial forever begin
        @(posedge ck);
        if (ativo_mon) begin
            if (rst) begin
                modelo.delete();
                em_uso = 1'b0;
                ultimo = '0;
            end else begin
                if (ent_valido && ent_pronto)
                    modelo.push_back(operandos_t'({ent_X, ent_A, ent_B, ent_C}));
                if (fim && em_uso && !inicio) em_uso = 1'b0;
            end
        end
        @(negedge ck);
        if (ativo_mon) begin
            if (inicio) begin
                chk("inicio_duplo", 64'(inicio_ant), 64'(0));
                chk("inicio_com_job", 64'(modelo.size() != 0), 64'(1));
                if (modelo.size() != 0) ultimo = modelo.pop_front();
                em_uso = 1'b1;
                chk("ops_carregados", 64'({X, A, B, C}), 64'(ultimo));
            end else begin
                chk("ops_mantidos", 64'({X, A, B, C}), 64'(ultimo));
            end
            chk("nivel", 64'(nivel), 64'(modelo.size()));
            chk("ent_pronto", 64'(ent_pronto), 64'(modelo.size() < PROF));
            chk("ocupado", 64'(ocupado), 64'(em_uso));
            inicio_ant = inicio;
        end
    end

    // Evaluator stand-in: manual fim requests, or automatic fim after a delay.
    initial begin
        fim = 1'b0;
        forever begin
            @(posedge ck);
            #1;
            fim = 1'b0;
            if (pedidos != atendidos) begin
                fim = 1'b1;
                atendidos++;
            end else if (auto_fim && inicio) begin
                cont = (fim_atraso != 0) ? fim_atraso : int'($urandom_range(1, 8));
            end else if (cont > 0) begin
                cont--;
                if (cont == 0) fim = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1);
    end

    task automatic push(input operandos_t s);
        bit aceito;
        aceito = 1'b0;
        {ent_X, ent_A, ent_B, ent_C} = s;
        ent_valido = 1'b1;
        for (int k = 0; k < 200 && !aceito; k++) begin
            @(negedge ck);
            aceito = ent_pronto;
            @(posedge ck);
        end
        #1 ent_valido = 1'b0;
        if (!aceito) chk("push_timeout", 64'(0), 64'(1));
    endtask

    task automatic esperar_fim();
        bit visto;
        visto = 1'b0;
        for (int k = 0; k < 100 && !visto; k++) begin
            @(posedge ck);
            visto = fim;
        end
        if (!visto) chk("fim_timeout", 64'(0), 64'(1));
    endtask

    task automatic pulso_fim();
        pedidos++;
        esperar_fim();
        #1;
    endtask

    task automatic esperar_ocioso(input string nome);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge ck);
            ok = (nivel == 0) && !ocupado && !inicio && (modelo.size() == 0);
        end
        chk(nome, 64'(ok), 64'(1));
        @(posedge ck);
        #1;
    endtask

    initial begin
        operandos_t s;
        int lat;
        rst = 1'b1;
        ent_valido = 1'b0;
        {ent_X, ent_A, ent_B, ent_C} = '0;

        @(posedge ck);
        ativo_mon = 1'b1;
        @(posedge ck);
        #1 rst = 1'b0;
        @(negedge ck);
        chk("reset_nivel", 64'(nivel), 64'(0));
        chk("reset_ocupado", 64'(ocupado), 64'(0));
        chk("reset_inicio", 64'(inicio), 64'(0));
        chk("reset_ops", 64'({X, A, B, C}), 64'(0));
        chk("reset_pronto", 64'(ent_pronto), 64'(1));
        @(posedge ck);
        #1;

        // Single job 2/3/4/5.
        fim_atraso = 5;
        auto_fim = 1'b1;
        s = {16'd2, 16'd3, 16'd4, 16'd5};
        push(s);
        lat = 0;
        for (int m = 1; m <= 6 && lat == 0; m++) begin
            @(negedge ck);
            if (inicio) lat = m;
        end
        chk("latencia_inicio", 64'(lat), 64'(2));
        chk("t1_ops", 64'({X, A, B, C}), 64'(s));
        esperar_fim();
        @(negedge ck);
        chk("t1_ocupado_cai", 64'(ocupado), 64'(0));
        @(posedge ck);
        #1;

        // Fill the FIFO while the evaluator is stalled.
        auto_fim = 1'b0;
        for (int j = 0; j < 5; j++) push(aleatorio());
        @(negedge ck);
        chk("t2_nivel_cheio", 64'(nivel), 64'(4));
        chk("t2_pronto_cheio", 64'(ent_pronto), 64'(0));
        @(posedge ck);
        #1;
        {ent_X, ent_A, ent_B, ent_C} = aleatorio();
        ent_valido = 1'b1;
        repeat (3) @(posedge ck);
        #1 ent_valido = 1'b0;
        @(negedge ck);
        chk("t2_sexto_recusado", 64'(nivel), 64'(4));
        @(posedge ck);
        #1;
        auto_fim = 1'b1;
        fim_atraso = 0;
        pulso_fim();
        esperar_ocioso("t2_drenagem");

        // Three jobs, fim 10 cycles after each start; check fim-to-inicio gap.
        fim_atraso = 10;
        for (int j = 0; j < 3; j++) push(aleatorio());
        for (int j = 0; j < 2; j++) begin
            esperar_fim();
            lat = 0;
            for (int m = 1; m <= 6 && lat == 0; m++) begin
                @(negedge ck);
                if (inicio) lat = m;
            end
            chk("gap_fim_inicio", 64'(lat), 64'(2));
        end
        esperar_ocioso("t3_drenagem");

        // Spurious fim while idle and empty.
        auto_fim = 1'b0;
        fim_atraso = 0;
        pulso_fim();
        lat = 0;
        repeat (4) begin
            @(negedge ck);
            if (inicio) lat = 1;
        end
        chk("espurio_sem_inicio", 64'(lat), 64'(0));
        chk("espurio_nivel", 64'(nivel), 64'(0));
        chk("espurio_ocupado", 64'(ocupado), 64'(0));
        @(posedge ck);
        #1;

        // Push on the same edge as a pop with two entries queued.
        for (int j = 0; j < 3; j++) push(aleatorio());
        pulso_fim();
        {ent_X, ent_A, ent_B, ent_C} = aleatorio();
        ent_valido = 1'b1;
        @(posedge ck);
        #1 ent_valido = 1'b0;
        @(negedge ck);
        chk("simult_nivel", 64'(nivel), 64'(2));
        chk("simult_inicio", 64'(inicio), 64'(1));
        @(posedge ck);
        #1;
        auto_fim = 1'b1;
        pulso_fim();

        // Random traffic across several pointer wraps.
        for (int j = 0; j < 14; j++) begin
            push(aleatorio());
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
                @(posedge ck);
                #1;
            end
        end
        esperar_ocioso("aleatorio_drenagem");

        // Reset while a job is in flight with three queued.
        auto_fim = 1'b0;
        for (int j = 0; j < 4; j++) push(aleatorio());
        @(negedge ck);
        chk("pre_reset_nivel", 64'(nivel), 64'(3));
        chk("pre_reset_ocupado", 64'(ocupado), 64'(1));
        @(posedge ck);
        #1 rst = 1'b1;
        @(posedge ck);
        #1 rst = 1'b0;
        @(negedge ck);
        chk("rst_nivel", 64'(nivel), 64'(0));
        chk("rst_ocupado", 64'(ocupado), 64'(0));
        chk("rst_inicio", 64'(inicio), 64'(0));
        chk("rst_ops", 64'({X, A, B, C}), 64'(0));
        chk("rst_pronto", 64'(ent_pronto), 64'(1));
        @(posedge ck);
        #1;
        pulso_fim();
        lat = 0;
        repeat (4) begin
            @(negedge ck);
            if (inicio || ocupado) lat = 1;
        end
        chk("fim_pos_reset_ignorado", 64'(lat), 64'(0));
        chk("pos_reset_nivel", 64'(nivel), 64'(0));

        $display("%0d/%0d checks passed", n_ok, n_tot);
        $finish;
    end

endmodule
